// File: rtl/serial_wide_adder_ctrl.sv
// rtl/serial_wide_adder_ctrl.sv - byte-serial wide add/subtract sequencer around one 8-bit adder
//
// serial_wide_adder_ctrl
//   Performs a W = 8*NBYTES bit add or subtract by feeding one byte slice per
//   clock through a single adder_8bits, LSB first, with the carry registered
//   between slices. Operands are captured when a start is accepted; a one-cycle
//   done pulse marks a coherent result, which is then held until overwritten.
//
//   Ports
//     clk     in   1  clock, rising edge
//     rst     in   1  synchronous active-high reset
//     start   in   1  operation request, accepted in IDLE or DONE only
//     sub     in   1  0: a+b+cin, 1: a-b (cin ignored)
//     cin     in   1  carry-in for add mode
//     a, b    in   W  operands, captured on accepted start
//     result  out  W  sum/difference, one byte written per RUN cycle
//     cout    out  1  final carry out (sub mode: 1 = no borrow)
//     ovf     out  1  signed overflow of the W-bit operation
//     busy    out  1  high while in RUN
//     done    out  1  one-cycle pulse, result/cout/ovf valid
//
// adder_8bits
//   Plain 8-bit ripple adder slice: {Cout,S} = A + B + Cin.

module adder_8bits (
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       Cin,
    output logic [7:0] S,
    output logic       Cout
);

    assign {Cout, S} = {1'b0, A} + {1'b0, B} + {8'b0, Cin};

endmodule

module serial_wide_adder_ctrl #(
    parameter int NBYTES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                sub,
    input  logic                cin,
    input  logic [8*NBYTES-1:0] a,
    input  logic [8*NBYTES-1:0] b,
    output logic [8*NBYTES-1:0] result,
    output logic                cout,
    output logic                ovf,
    output logic                busy,
    output logic                done
);

    localparam int              IW   = $clog2(NBYTES);
    localparam logic [IW-1:0]   LAST = IW'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                   state;
    state_t                   state_nx;

    // Operands and result are kept as byte arrays so the slice select is a
    // plain index by idx.
    logic [NBYTES-1:0][7:0]   opa;
    logic [NBYTES-1:0][7:0]   opb;
    logic [NBYTES-1:0][7:0]   res_q;
    logic                     carry;
    logic [IW-1:0]            idx;
    logic                     cout_q;
    logic                     ovf_q;

    logic [7:0]               slice_s;
    logic                     slice_co;
    logic                     accept;
    logic                     last_slice;

    assign accept     = start && ((state == IDLE) || (state == DONE));
    assign last_slice = (idx == LAST);

    adder_8bits u_adder (
        .A    (opa[idx]),
        .B    (opb[idx]),
        .Cin  (carry),
        .S    (slice_s),
        .Cout (slice_co)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? RUN : IDLE;
            RUN:     state_nx = last_slice ? DONE : RUN;
            DONE:    state_nx = accept ? RUN : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Status outputs decoded from state
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Datapath. Subtraction is a + ~b + 1, so b is inverted at capture and the
    // carry register is preset to 1. idx parks on the last slice rather than
    // wrapping; it is reloaded on the next accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            opa    <= '0;
            opb    <= '0;
            res_q  <= '0;
            carry  <= 1'b0;
            idx    <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (accept) begin
            opa   <= a;
            opb   <= sub ? ~b : b;
            carry <= sub | cin;
            idx   <= '0;
        end else if (state == RUN) begin
            res_q[idx] <= slice_s;
            carry      <= slice_co;
            if (last_slice) begin
                cout_q <= slice_co;
                // Overflow: both adder inputs share a sign and the sum's sign differs.
                ovf_q  <= (opa[NBYTES-1][7] == opb[NBYTES-1][7]) &&
                          (slice_s[7] != opa[NBYTES-1][7]);
            end else begin
                idx <= idx + IW'(1);
            end
        end
    end

    assign result = res_q;
    assign cout   = cout_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_serial_wide_adder_ctrl.sv
// tb/tb_serial_wide_adder_ctrl.sv - scoreboard bench for serial_wide_adder_ctrl

module tb_serial_wide_adder_ctrl;

    localparam int NBYTES = 4;
    localparam int W      = 8 * NBYTES;

    typedef struct packed {
        logic [W-1:0] r;
        logic         c;
        logic         v;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         sub;
    logic         cin;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;
    logic         busy;
    logic         done;

    int   checks = 0;
    int   errors = 0;
    exp_t scb[$];

    serial_wide_adder_ctrl #(.NBYTES(NBYTES)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .sub    (sub),
        .cin    (cin),
        .a      (a),
        .b      (b),
        .result (result),
        .cout   (cout),
        .ovf    (ovf),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain signed/unsigned arithmetic on the whole W-bit values.
    function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                   input logic msub, input logic mcin);
        exp_t         e;
        longint       sa;
        longint       sbv;
        longint       tr;
        longint       lim;
        logic [W:0]   full;
        lim = longint'(1) << (W - 1);
        sa  = longint'($signed(ma));
        sbv = longint'($signed(mb));
        if (msub) begin
            full = {1'b0, ma} - {1'b0, mb};
            e.c  = (ma >= mb);
            tr   = sa - sbv;
        end else begin
            full = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mcin};
            e.c  = full[W];
            tr   = sa + sbv + longint'(mcin);
        end
        e.r = full[W-1:0];
        e.v = (tr >= lim) || (tr < -lim);
        return e;
    endfunction

    // Monitor: every done pulse is checked against the oldest expectation.
    always @(negedge clk) begin
        if (done) begin
            if (scb.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = scb.pop_front();
                chk("result", 64'(result), 64'(e.r));
                chk("cout", 64'(cout), 64'(e.c));
                chk("ovf", 64'(ovf), 64'(e.v));
            end
        end
    end

    // Called on a falling edge; the request is sampled on the next rising edge.
    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic isub, input logic icin, input bit push);
        a     = ia;
        b     = ib;
        sub   = isub;
        cin   = icin;
        start = 1'b1;
        if (push) scb.push_back(model(ia, ib, isub, icin));
    endtask

    // Counts falling edges from the issue until done; scrambles the inputs after
    // acceptance and optionally re-pulses start mid-RUN.
    task automatic wait_done(input bit poke, output int k, output int nb);
        bit seen;
        seen = 1'b0;
        k    = 0;
        nb   = 0;
        while (!seen && k < 20) begin
            @(negedge clk);
            k++;
            if (busy) nb++;
            if (done) seen = 1'b1;
            if (k == 1) begin
                start = 1'b0;
                a     = $urandom;
                b     = $urandom;
                sub   = 1'($urandom);
                cin   = 1'($urandom);
            end
            if (poke && k == 2) begin
                start = 1'b1;
                a     = $urandom;
                b     = $urandom;
                sub   = ~sub;
            end
            if (poke && k == 3) start = 1'b0;
        end
        chk("done_seen", 64'(seen), 64'd1);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return {1'b1, {(W-1){1'b0}}};
            3:       return {1'b0, {(W-1){1'b1}}};
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int k;
        int nb;
        int dcnt;

        rst   = 1'b1;
        start = 1'b0;
        sub   = 1'b0;
        cin   = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_cout", 64'(cout), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        issue(32'h000000FF, 32'h00000001, 1'b0, 1'b0, 1'b1);
        wait_done(1'b0, k, nb);
        chk("latency", 64'(k), 64'(NBYTES + 1));
        chk("busy_cycles", 64'(nb), 64'(NBYTES));

        @(negedge clk);
        issue(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b1);
        wait_done(1'b0, k, nb);
        @(negedge clk);
        issue(32'h7FFFFFFF, 32'h00000000, 1'b0, 1'b1, 1'b1);
        wait_done(1'b0, k, nb);

        @(negedge clk);
        issue(32'h00000005, 32'h00000007, 1'b1, 1'b1, 1'b1);
        wait_done(1'b0, k, nb);
        @(negedge clk);
        issue(32'h80000000, 32'h00000001, 1'b1, 1'b1, 1'b1);
        wait_done(1'b0, k, nb);

        // start mid-RUN is ignored
        @(negedge clk);
        issue(32'h12345678, 32'h11111111, 1'b0, 1'b0, 1'b1);
        wait_done(1'b1, k, nb);
        chk("poke_latency", 64'(k), 64'(NBYTES + 1));
        repeat (NBYTES + 2) @(negedge clk);
        chk("poke_no_extra", 64'(scb.size()), 64'd0);

        // back-to-back: start during the DONE cycle
        issue(32'hDEADBEEF, 32'h01020304, 1'b0, 1'b1, 1'b1);
        wait_done(1'b0, k, nb);
        issue(32'h00001000, 32'h00002000, 1'b1, 1'b0, 1'b1);
        wait_done(1'b0, k, nb);
        chk("b2b_gap", 64'(k), 64'(NBYTES + 1));

        // reset in the third RUN cycle aborts the op
        @(negedge clk);
        issue(32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_result", 64'(result), 64'd0);
        chk("abort_cout", 64'(cout), 64'd0);
        chk("abort_ovf", 64'(ovf), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        dcnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("abort_no_done", 64'(dcnt), 64'd0);
        issue(32'h0F0F0F0F, 32'h00000001, 1'b0, 1'b0, 1'b1);
        wait_done(1'b0, k, nb);
        chk("after_abort_latency", 64'(k), 64'(NBYTES + 1));

        // random regression, mixing idle gaps and back-to-back starts
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 1) == 1) @(negedge clk);
            issue(pick(), pick(), 1'($urandom), 1'($urandom), 1'b1);
            wait_done(1'b0, k, nb);
            chk("rand_latency", 64'(k), 64'(NBYTES + 1));
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(scb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
